fft_sample_loader: RTL
======================

FFT_SAMPLE_LOADER -- requirements
Module: fft_sample_loader

Interface
REQ-001 SHALL have parameter N_SAMPLES, default 8, the FFT points per frame (power of two, >=2).
REQ-002 SHALL have parameter DATA_SIZE, default 16, the width of each real/imaginary component.
REQ-003 SHALL have port clk, input, 1, the rising-edge clock.
REQ-004 SHALL have port rst_n, input, 1, the synchronous active-low reset.
REQ-005 SHALL have port s_valid, input, 1, meaning an input sample is offered.
REQ-006 SHALL have port s_ready, output, 1, meaning the loader accepts a sample this cycle.
REQ-007 SHALL have port s_re, input, DATA_SIZE, the real part, two's complement.
REQ-008 SHALL have port s_im, input, DATA_SIZE, the imaginary part, two's complement.
REQ-009 SHALL have port mem_we, output, 1, the FFT sample-RAM write enable.
REQ-010 SHALL have port mem_addr, output, $clog2(N_SAMPLES), the RAM write address.
REQ-011 SHALL have port mem_wdata, output, 2*DATA_SIZE, the RAM write data {re, im} with re in the MSBs.
REQ-012 SHALL have port fft_start, output, 1, a one-cycle start pulse to the FFT core.
REQ-013 SHALL have port fft_finish, input, 1, the FFT-core completion indication.
REQ-014 SHALL have port busy, output, 1, high whenever the state is not LOAD.
REQ-015 SHALL have port frame_count, output, 16, the number of frames handed to the FFT core, wrapping modulo 2^16.

Function
REQ-016 SHALL implement states LOAD, START and WAIT.
REQ-017 In LOAD: s_ready=1; a sample is accepted on any cycle with s_valid && s_ready.
REQ-018 Each accepted sample SHALL produce exactly one RAM write, on the following cycle: mem_we=1, mem_addr=map(idx), mem_wdata={s_re,s_im}, where idx is the sample's 0-based position in the frame.
REQ-019 When s_valid=0 in LOAD, the next cycle SHALL have mem_we=0, with no gap penalty.
REQ-020 The sample index counter SHALL increment per accept and return to 0 after the acceptance with idx=N_SAMPLES-1.
REQ-021 On acceptance of idx=N_SAMPLES-1, the next state SHALL be START; s_ready SHALL be 0 in START and WAIT.
REQ-022 START SHALL last one cycle, coincident with the last RAM write: fft_start=0 that cycle, next state WAIT.
REQ-023 On entering WAIT, fft_start SHALL pulse high for exactly one cycle (the cycle after the last write), and frame_count SHALL increment that cycle.
REQ-024 fft_finish SHALL be ignored in LOAD, in START, and in the fft_start pulse cycle.
REQ-025 In WAIT, fft_finish=1 on any later cycle SHALL return the state to LOAD next cycle, with s_ready=1 from that cycle onward.
REQ-026 fft_finish SHALL be level-tolerant: a held-high fft_finish causes one return to LOAD only, and LOAD does not re-exit until a full frame is accepted.
REQ-027 Minimum frame-to-start latency from first accept is N_SAMPLES+1 cycles to the fft_start pulse.
REQ-028 The mem_wdata, mem_addr and mem_we outputs SHALL be registered.

Reset
REQ-029 While rst_n=0 at a clk edge: state=LOAD, idx=0, mem_we=0, mem_addr=0, mem_wdata=0, fft_start=0, frame_count=0.
REQ-030 After reset, s_ready=1 and busy=0 from the first cycle after reset deassertion.
REQ-031 Reset mid-frame SHALL discard partial samples with no further writes; reset in WAIT SHALL abandon the frame without an fft_start pulse.

Configuration
REQ-032 With macro FFT_LOADER_BITREV_EN defined, map(idx) SHALL be the $clog2(N_SAMPLES)-bit bit-reversal of idx, giving in-place DIT input order.
REQ-033 Without FFT_LOADER_BITREV_EN, map(idx)=idx (natural order), and all other behaviour SHALL be identical.

Verification
REQ-034 N=8, BITREV on, stream samples re=k, im=-k for k=0..7 with no gaps -> writes to addresses 0,4,2,6,1,5,3,7 with data {k,-k}, fft_start pulses 1 cycle after the 8th write, frame_count=1.
REQ-035 Same stream with BITREV off -> addresses 0..7 in order, identical timing.
REQ-036 s_valid toggled 1,0,1,0 across the frame -> exactly 8 writes, no duplicates; fft_start arrives 1 cycle after the last write.
REQ-037 fft_finish held high throughout and a second frame offered -> s_ready stays 0 until the pulse cycle passes, then one return to LOAD, frame 2 fully accepted, frame_count=2.
REQ-038 rst_n asserted after 5 accepts, then a fresh full frame -> indices restart at 0, frame_count=1 after the frame, and no stale writes occur.

Source files
------------

// File: rtl/fft_sample_loader.sv
// ============================================================================
// Module      : fft_sample_loader
// Description : Streams one frame of N_SAMPLES complex samples into the FFT
//               sample RAM, then hands the frame to the FFT core with a
//               one-cycle start pulse and waits for its completion.
//               Define FFT_LOADER_BITREV_EN to write samples at bit-reversed
//               addresses (in-place DIT input order); otherwise natural order.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_sample_loader #(
  parameter int N_SAMPLES = 8,
  parameter int DATA_SIZE = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [DATA_SIZE-1:0]         s_re,
  input  logic [DATA_SIZE-1:0]         s_im,
  output logic                         mem_we,
  output logic [$clog2(N_SAMPLES)-1:0] mem_addr,
  output logic [2*DATA_SIZE-1:0]       mem_wdata,
  output logic                         fft_start,
  input  logic                         fft_finish,
  output logic                         busy,
  output logic [15:0]                  frame_count
);

  localparam int c_aw = $clog2(N_SAMPLES);
  localparam logic [c_aw-1:0] c_last = c_aw'(N_SAMPLES - 1);
  localparam logic [c_aw-1:0] c_one  = c_aw'(1);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t                 r_state;
  logic [c_aw-1:0]        r_idx;
  logic                   r_mem_we;
  logic [c_aw-1:0]        r_mem_addr;
  logic [2*DATA_SIZE-1:0] r_mem_wdata;
  logic                   r_fft_start;
  logic [15:0]            r_frame_count;

  logic                   w_ready;
  logic                   w_accept;

  // Sample position in the frame to RAM address.
  function automatic logic [c_aw-1:0] f_map(input logic [c_aw-1:0] idx);
    logic [c_aw-1:0] v_addr;
`ifdef FFT_LOADER_BITREV_EN
    for (int b = 0; b < c_aw; b++) begin
      v_addr[b] = idx[c_aw-1-b];
    end
`else
    v_addr = idx;
`endif
    return v_addr;
  endfunction

  // Ready only while collecting a frame; handshake qualifies acceptance.
  always_comb begin
    w_ready  = (r_state == ST_LOAD);
    w_accept = s_valid && w_ready;
  end

  // Frame sequencer: RAM write per accept, start pulse, completion wait.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_LOAD;
      r_idx         <= '0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_fft_start   <= 1'b0;
      r_frame_count <= 16'd0;
    end else begin
      r_mem_we    <= w_accept;
      r_fft_start <= 1'b0;
      if (w_accept) begin
        r_mem_addr  <= f_map(r_idx);
        r_mem_wdata <= {s_re, s_im};
      end
      case (r_state)
        ST_LOAD: begin
          if (w_accept) begin
            if (r_idx == c_last) begin
              r_idx   <= '0;
              r_state <= ST_START;
            end else begin
              r_idx <= r_idx + c_one;
            end
          end
        end
        ST_START: begin
          // Last RAM write is on the bus this cycle; start fires next.
          r_state       <= ST_WAIT;
          r_fft_start   <= 1'b1;
          r_frame_count <= r_frame_count + 16'd1;
        end
        ST_WAIT: begin
          // A finish level seen during the pulse cycle belongs to the
          // previous job, so it is ignored there.
          if (!r_fft_start && fft_finish) begin
            r_state <= ST_LOAD;
          end
        end
        default: r_state <= ST_LOAD;
      endcase
    end
  end

  assign s_ready     = w_ready;
  assign busy        = !w_ready;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign fft_start   = r_fft_start;
  assign frame_count = r_frame_count;

endmodule

`default_nettype wire
